// File: rtl/msg_emitter.sv
// rtl/msg_emitter.sv - fixed-table message emitter with optional CR/LF prefix
// Streams one of four constant messages a character per beat over a valid/ready handshake.
module msg_emitter #(
  parameter int DATA_W   = 8,
  parameter int N_MSG    = 4,
  parameter int MAX_LEN  = 32,
  parameter int ADD_CRLF = 1,
  localparam int ID_W    = (N_MSG > 1) ? $clog2(N_MSG) : 1,
  localparam int IDX_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ID_W-1:0]   msg_id,
  output logic              ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              next_line,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_CR, S_LF, S_TEXT, S_DONE} state_t;

  localparam logic [8*18-1:0] MSG1 = "Command unknown:> ";

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [1:0]       id_q, id_nx;
  logic             err_nx;
  logic             beat;
  logic             id_ok;
  logic [IDX_W-1:0] last_idx;

  function automatic logic [IDX_W-1:0] msg_len(input logic [1:0] id);
    logic [IDX_W-1:0] n;
    case (id)
      2'd0:    n = IDX_W'(2);
      2'd1:    n = IDX_W'(18);
      2'd2:    n = IDX_W'(2);
      default: n = IDX_W'(3);
    endcase
    return n;
  endfunction

  function automatic logic [7:0] msg_char(input logic [1:0] id, input logic [IDX_W-1:0] i);
    logic [7:0] c;
    c = 8'h00;
    case (id)
      2'd0:    c = (i == '0) ? 8'h3E : 8'h20;
      2'd1:    if (int'(i) < 18) c = MSG1[8*(17-int'(i)) +: 8];
      2'd2:    c = (i == '0) ? 8'h4F : 8'h4B;
      default: c = (i == '0) ? 8'h45 : 8'h52;
    endcase
    return c;
  endfunction

  assign beat     = out_valid & out_ready;
  assign id_ok    = int'(msg_id) < N_MSG;
  assign last_idx = msg_len(id_q) - IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      id_q  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      id_q  <= id_nx;
      err   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    id_nx    = id_q;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (id_ok) begin
            id_nx    = 2'(msg_id);
            idx_nx   = '0;
            state_nx = (ADD_CRLF != 0) ? S_CR : S_TEXT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_CR:   if (beat) state_nx = S_LF;
      S_LF: begin
        if (beat) begin
          state_nx = S_TEXT;
          idx_nx   = '0;
        end
      end
      S_TEXT: begin
        // Stop on the last character so the index never wraps past the message.
        if (beat) begin
          if (idx == last_idx) state_nx = S_DONE;
          else                 idx_nx   = idx + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == S_IDLE);
    out_valid = (state == S_CR) || (state == S_LF) || (state == S_TEXT);
    next_line = (state == S_LF);
    done      = (state == S_DONE);
    case (state)
      S_CR:    out_data = DATA_W'(8'h0D);
      S_LF:    out_data = DATA_W'(8'h0A);
      S_TEXT:  out_data = DATA_W'(msg_char(id_q, idx));
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_msg_emitter.sv
// tb/tb_msg_emitter.sv - directed self-checking bench for msg_emitter
// Three instances: default, N_MSG=3, and ADD_CRLF=0.
module tb_msg_emitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start, out_ready, ready, out_valid, next_line, done, err;
  logic [1:0] msg_id;
  logic [7:0] out_data;

  logic       s3_start, s3_out_ready, s3_ready, s3_out_valid, s3_next_line, s3_done, s3_err;
  logic [1:0] s3_msg_id;
  logic [7:0] s3_out_data;

  logic       c_start, c_out_ready, c_ready, c_out_valid, c_next_line, c_done, c_err;
  logic [1:0] c_msg_id;
  logic [7:0] c_out_data;

  msg_emitter u_dut (
    .clk(clk), .rst(rst), .start(start), .msg_id(msg_id), .ready(ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .next_line(next_line), .done(done), .err(err)
  );

  msg_emitter #(.N_MSG(3)) u_n3 (
    .clk(clk), .rst(rst), .start(s3_start), .msg_id(s3_msg_id), .ready(s3_ready),
    .out_data(s3_out_data), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
    .next_line(s3_next_line), .done(s3_done), .err(s3_err)
  );

  msg_emitter #(.ADD_CRLF(0)) u_nc (
    .clk(clk), .rst(rst), .start(c_start), .msg_id(c_msg_id), .ready(c_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .next_line(c_next_line), .done(c_done), .err(c_err)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_b [0:19];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_main(input logic [1:0] id);
    msg_id = id;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Expects the current cycle to present exp_b[0]; optionally pulses a stray start.
  task automatic run_main(input string tag, input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " data"}, 32'(out_data), 32'(exp_b[i]));
      check({tag, " next_line"}, 32'(next_line), 32'(exp_b[i] == 8'h0A));
      check({tag, " ready_busy"}, 32'(ready), 32'd0);
      check({tag, " no_early_done"}, 32'(done), 32'd0);
      if (i == pulse_at) begin
        msg_id = 2'd3;
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " valid_in_done"}, 32'(out_valid), 32'd0);
    check({tag, " data_in_done"}, 32'(out_data), 32'd0);
    tick();
    check({tag, " ready_after"}, 32'(ready), 32'd1);
    check({tag, " done_cleared"}, 32'(done), 32'd0);
  endtask

  task automatic load_msg1();
    exp_b[0] = 8'h0D; exp_b[1] = 8'h0A; exp_b[2] = 8'h43; exp_b[3] = 8'h6F;
    exp_b[4] = 8'h6D; exp_b[5] = 8'h6D; exp_b[6] = 8'h61; exp_b[7] = 8'h6E;
    exp_b[8] = 8'h64; exp_b[9] = 8'h20; exp_b[10] = 8'h75; exp_b[11] = 8'h6E;
    exp_b[12] = 8'h6B; exp_b[13] = 8'h6E; exp_b[14] = 8'h6F; exp_b[15] = 8'h77;
    exp_b[16] = 8'h6E; exp_b[17] = 8'h3A; exp_b[18] = 8'h3E; exp_b[19] = 8'h20;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; msg_id = '0; out_ready = 1'b1;
    s3_start = 1'b0; s3_msg_id = '0; s3_out_ready = 1'b1;
    c_start = 1'b0; c_msg_id = '0; c_out_ready = 1'b1;
    tick();
    tick();
    check("rst ready", 32'(ready), 32'd1);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst data", 32'(out_data), 32'd0);
    check("rst next_line", 32'(next_line), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    check("idle ready", 32'(ready), 32'd1);

    // Message 1, full throughput.
    load_msg1();
    start_main(2'd1);
    run_main("m1", 20, -1);

    // Message 2 with a stall before every beat.
    exp_b[0] = 8'h0D; exp_b[1] = 8'h0A; exp_b[2] = 8'h4F; exp_b[3] = 8'h4B;
    out_ready = 1'b0;
    start_main(2'd2);
    for (int i = 0; i < 4; i++) begin
      check("m2 stall data", 32'(out_data), 32'(exp_b[i]));
      check("m2 stall nl", 32'(next_line), 32'(exp_b[i] == 8'h0A));
      tick();
      check("m2 held valid", 32'(out_valid), 32'd1);
      check("m2 held data", 32'(out_data), 32'(exp_b[i]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("m2 done", 32'(done), 32'd1);
    tick();
    check("m2 ready", 32'(ready), 32'd1);
    out_ready = 1'b1;

    // Stray start during TEXT is dropped, not queued.
    load_msg1();
    start_main(2'd1);
    run_main("m1_busy", 20, 6);
    for (int i = 0; i < 4; i++) begin
      check("busy no_restart", 32'(out_valid), 32'd0);
      check("busy no_done", 32'(done), 32'd0);
      tick();
    end

    // Invalid id on the N_MSG=3 instance.
    check("n3 err idle", 32'(s3_err), 32'd0);
    s3_msg_id = 2'd3;
    s3_start  = 1'b1;
    tick();
    s3_start  = 1'b0;
    check("n3 err pulse", 32'(s3_err), 32'd1);
    check("n3 ready", 32'(s3_ready), 32'd1);
    check("n3 valid", 32'(s3_out_valid), 32'd0);
    tick();
    check("n3 err one_cycle", 32'(s3_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("n3 valid_low", 32'(s3_out_valid), 32'd0);
      check("n3 ready_hold", 32'(s3_ready), 32'd1);
      tick();
    end

    // Asynchronous reset in the middle of message 1.
    start_main(2'd1);
    for (int i = 0; i < 4; i++) tick();
    check("abort fifth", 32'(out_data), 32'h6D);
    #2 rst = 1'b1;
    #1;
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort ready", 32'(ready), 32'd1);
    check("abort data", 32'(out_data), 32'd0);
    tick();
    check("abort no_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    exp_b[0] = 8'h0D; exp_b[1] = 8'h0A; exp_b[2] = 8'h3E; exp_b[3] = 8'h20;
    start_main(2'd0);
    run_main("m0_after_rst", 4, -1);

    // No CR/LF prefix.
    c_msg_id = 2'd0;
    c_start  = 1'b1;
    tick();
    c_start  = 1'b0;
    check("nc first valid", 32'(c_out_valid), 32'd1);
    check("nc data0", 32'(c_out_data), 32'h3E);
    check("nc nl0", 32'(c_next_line), 32'd0);
    tick();
    check("nc data1", 32'(c_out_data), 32'h20);
    check("nc nl1", 32'(c_next_line), 32'd0);
    tick();
    check("nc done", 32'(c_done), 32'd1);
    check("nc valid_done", 32'(c_out_valid), 32'd0);
    tick();
    check("nc ready", 32'(c_ready), 32'd1);
    check("nc err", 32'(c_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msg_emitter.md
MSG_EMITTER -- requirements
Module: msg_emitter

Interface
- REQ-001 SHALL provide parameter DATA_W, default 8: character width in bits; values of 8 or more are legal, and characters are zero-extended.
- REQ-002 SHALL provide parameter N_MSG, default 4: number of enabled messages, legal range 1..4.
- REQ-003 SHALL provide parameter MAX_LEN, default 32: maximum text length per message; must be at least 18.
- REQ-004 SHALL provide parameter ADD_CRLF, default 1: 1 = prefix every message with CR (0x0D) then LF (0x0A).
- REQ-005 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-006 SHALL provide port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-007 SHALL provide port start, input, 1 bit: emission request, sampled only while ready=1.
- REQ-008 SHALL provide port msg_id, input, clog2(N_MSG) bits (minimum 1): selects the message; sampled with start.
- REQ-009 SHALL provide port ready, output, 1 bit: idle, able to accept start.
- REQ-010 SHALL provide port out_data, output, DATA_W bits: current character.
- REQ-011 SHALL provide port out_valid, output, 1 bit: out_data is valid.
- REQ-012 SHALL provide port out_ready, input, 1 bit: the sink accepts the character; a beat is out_valid and out_ready both high at a rising edge.
- REQ-013 SHALL provide port next_line, output, 1 bit: high while the LF character is presented.
- REQ-014 SHALL provide port done, output, 1 bit: one-cycle pulse at the end of a message.
- REQ-015 SHALL provide port err, output, 1 bit: one-cycle pulse when a request selects an invalid msg_id.

Function
- REQ-016 SHALL hold a fixed message table: id0 = "> " (3E 20); id1 = "Command unknown:> " (18 chars); id2 = "OK" (4F 4B); id3 = "ERR" (45 52 52). Table entries are indexed by id and have no terminators.
- REQ-017 SHALL implement the states IDLE, CR, LF, TEXT and DONE; ready=1 only in IDLE.
- REQ-018 SHALL, in IDLE with start=1 and msg_id<N_MSG, latch msg_id and then move to CR when ADD_CRLF=1, otherwise to TEXT with the character index at 0.
- REQ-019 SHALL, in IDLE with start=1 and msg_id>=N_MSG, pulse err for one cycle, stay in IDLE, and never assert out_valid.
- REQ-020 SHALL assert out_valid in the cycle after start is accepted, giving a latency of 1 cycle.
- REQ-021 SHALL keep out_valid high in the CR, LF and TEXT states and low in the IDLE and DONE states.
- REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0; no character is dropped or duplicated.
- REQ-023 SHALL advance on each beat: CR to LF, LF to TEXT with index 0, and in TEXT either increment the index or, on the last character, go to DONE.
- REQ-024 SHALL sustain one character per cycle while out_ready is held at 1.
- REQ-025 SHALL keep the index counter at clog2(MAX_LEN+1) bits; the index never exceeds the message length minus 1, with no wrap-around.
- REQ-026 SHALL spend exactly one cycle in DONE with done=1, then return to IDLE with ready=1.
- REQ-027 SHALL ignore start and msg_id in every state other than IDLE; a request made while busy is lost and is not queued.
- REQ-028 SHALL tie next_line to the condition state==LF; next_line is never asserted when ADD_CRLF=0.
- REQ-029 SHALL drive out_data to 0 whenever out_valid=0.

Reset
- REQ-030 SHALL, while rst=1, immediately force the state to IDLE, the index and latched id to 0, ready=1, and out_valid=0, out_data=0, next_line=0, done=0, err=0.
- REQ-031 SHALL abort any message when rst asserts mid-message, with no done pulse; after release, the next start begins again from the first character (CR, or text index 0).

Verification
- REQ-032 SHALL cover: reset, then start with msg_id=1, out_ready=1, ADD_CRLF=1. Required: 20 consecutive beats 0D 0A 43 6F 6D 6D 61 6E 64 20 75 6E 6B 6E 6F 77 6E 3A 3E 20; first valid 1 cycle after start; done in the cycle after the last beat; ready=1 the following cycle.
- REQ-033 SHALL cover: msg_id=2 with out_ready toggling 0,1,0,1. Required: beats exactly 0D 0A 4F 4B; data held steady through stall cycles; next_line high only with 0A.
- REQ-034 SHALL cover: start pulsed with msg_id=3 during TEXT of msg 1. Required: the request is ignored, msg 1 completes unaltered, and exactly one done pulse occurs.
- REQ-035 SHALL cover: N_MSG=3, start with msg_id=3. Required: err=1 for one cycle, ready stays 1, and out_valid never rises.
- REQ-036 SHALL cover: rst asserted at the 5th beat of msg 1. Required: out_valid=0 and ready=1 without waiting for a clock edge; after release, start with msg_id=0 yields 0D 0A 3E 20.
- REQ-037 SHALL cover: ADD_CRLF=0, msg_id=0. Required: beats 3E 20 only; next_line stays 0; done 1 cycle after the 20 beat.
